// File: rtl/l1dir_mc.sv
// Multi-CPU L1 coherence directory: shadow valid/tag copies of NCPU L1 caches.
// Each request runs READ (tag RAM read) then CMP (compare, report, commit).
module l1dir_mc #(
    parameter int NCPU  = 2,
    parameter int WAYS  = 4,
    parameter int IDX_W = 7,
    parameter int TAG_W = 29,
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int CPU_W = (NCPU > 1) ? $clog2(NCPU) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      strobe,
    input  logic [CPU_W-1:0]          cpu,
    input  logic [IDX_W-1:0]          index,
    input  logic [TAG_W-1:0]          tag,
    input  logic [WAY_W-1:0]          way,
    input  logic                      allocate,
    input  logic [NCPU-1:0]           dealloc_mask,
    input  logic                      invalidate,
    output logic                      ready,
    output logic                      done,
    output logic [NCPU-1:0]           hit,
    output logic [NCPU*WAY_W-1:0]     hit_way,
    output logic [NCPU*(WAY_W+1)-1:0] inval_vec,
    output logic                      othercpuhit,
    output logic                      multihit
);

    // state  | meaning
    // S_INIT | walk every set, clearing all valid bits
    // S_IDLE | ready, waiting for strobe
    // S_READ | tag RAM read of the latched set
    // S_CMP  | compare, drive results, commit updates
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_READ, S_CMP} state_t;

    localparam int SETS = 2 ** IDX_W;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   init_cnt;

    logic [CPU_W-1:0]   cpu_q;
    logic [IDX_W-1:0]   idx_q;
    logic [TAG_W-1:0]   tag_q;
    logic [WAY_W-1:0]   way_q;
    logic               alloc_q;
    logic               inv_q;
    logic [NCPU-1:0]    dealloc_q;

    logic [TAG_W-1:0]   tag_mem [NCPU][WAYS][SETS];
    logic [TAG_W-1:0]   rd_tag  [NCPU][WAYS];
    logic [WAYS-1:0]    valid   [NCPU][SETS];

    logic [WAYS-1:0]            match [NCPU];
    logic [NCPU-1:0]            hit_c;
    logic [NCPU*WAY_W-1:0]      hit_way_c;
    logic [NCPU*(WAY_W+1)-1:0]  inval_c;
    logic                       other_c;
    logic                       multi_c;

    logic [NCPU-1:0]            hit_h;
    logic [NCPU*WAY_W-1:0]      hit_way_h;
    logic [NCPU*(WAY_W+1)-1:0]  inval_h;
    logic                       other_h;
    logic                       multi_h;

    logic                       in_cmp;
    logic                       tag_we;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_INIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT: if (&init_cnt) state_d = S_IDLE;
            S_IDLE: if (strobe)    state_d = S_READ;
            S_READ:                state_d = S_CMP;
            S_CMP:                 state_d = S_IDLE;
            default:               state_d = S_INIT;
        endcase
    end

    // Counter parks at SETS-1 so it never wraps into live traffic.
    always_ff @(posedge clk) begin
        if (reset)                                init_cnt <= '0;
        else if (state_q == S_INIT && !(&init_cnt)) init_cnt <= init_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && strobe) begin
            cpu_q     <= cpu;
            idx_q     <= index;
            tag_q     <= tag;
            way_q     <= way;
            alloc_q   <= allocate;
            inv_q     <= invalidate;
            dealloc_q <= dealloc_mask;
        end
    end

    assign in_cmp = (state_q == S_CMP) && !reset;
    assign tag_we = in_cmp && alloc_q && !inv_q;

    always_ff @(posedge clk) begin
        for (int c = 0; c < NCPU; c++) begin
            for (int w = 0; w < WAYS; w++) begin
                if (state_q == S_READ)
                    rd_tag[c][w] <= tag_mem[c][w][idx_q];
                if (tag_we && cpu_q == CPU_W'(c) && way_q == WAY_W'(w))
                    tag_mem[c][w][idx_q] <= tag_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NCPU; c++) begin
            if (state_q == S_INIT) begin
                valid[c][init_cnt] <= '0;
            end else if (in_cmp) begin
                if (inv_q && cpu_q == CPU_W'(c))
                    valid[c][idx_q][way_q] <= 1'b0;
                else if (alloc_q && cpu_q == CPU_W'(c))
                    valid[c][idx_q][way_q] <= 1'b1;
                else if (dealloc_q[c] && hit_c[c])
                    valid[c][idx_q] <= valid[c][idx_q] & ~match[c];
            end
        end
    end

    always_comb begin
        hit_c     = '0;
        hit_way_c = '0;
        inval_c   = '0;
        other_c   = 1'b0;
        multi_c   = 1'b0;
        for (int c = 0; c < NCPU; c++) begin
            match[c] = '0;
            for (int w = 0; w < WAYS; w++)
                match[c][w] = valid[c][idx_q][w] && (rd_tag[c][w] == tag_q);
            hit_c[c] = |match[c];
            // Descending scan leaves the lowest matching way.
            for (int w = WAYS - 1; w >= 0; w--)
                if (match[c][w]) hit_way_c[c*WAY_W +: WAY_W] = WAY_W'(w);
            multi_c = multi_c | ((match[c] & (match[c] - WAYS'(1))) != '0);
            inval_c[c*(WAY_W+1) +: (WAY_W+1)] =
                {hit_c[c] & dealloc_q[c], hit_way_c[c*WAY_W +: WAY_W]};
            if (cpu_q != CPU_W'(c)) other_c = other_c | hit_c[c];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_h     <= '0;
            hit_way_h <= '0;
            inval_h   <= '0;
            other_h   <= 1'b0;
            multi_h   <= 1'b0;
        end else if (state_q == S_CMP) begin
            hit_h     <= hit_c;
            hit_way_h <= hit_way_c;
            inval_h   <= inval_c;
            other_h   <= other_c;
            multi_h   <= multi_c;
        end
    end

    assign ready       = (state_q == S_IDLE);
    assign done        = (state_q == S_CMP);
    assign hit         = done ? hit_c     : hit_h;
    assign hit_way     = done ? hit_way_c : hit_way_h;
    assign inval_vec   = done ? inval_c   : inval_h;
    assign othercpuhit = done ? other_c   : other_h;
    assign multihit    = done ? multi_c   : multi_h;

endmodule

// File: tb/tb_l1dir_mc.sv
// Self-checking bench for l1dir_mc (default parameters: 2 CPUs, 4 ways, 128 sets).
module tb_l1dir_mc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        strobe = 1'b0;
    logic [0:0]  cpu = '0;
    logic [6:0]  index = '0;
    logic [28:0] tag = '0;
    logic [1:0]  way = '0;
    logic        allocate = 1'b0;
    logic [1:0]  dealloc_mask = '0;
    logic        invalidate = 1'b0;
    logic        ready, done, othercpuhit, multihit;
    logic [1:0]  hit;
    logic [3:0]  hit_way;
    logic [5:0]  inval_vec;

    l1dir_mc dut (
        .clk(clk), .reset(reset), .strobe(strobe), .cpu(cpu), .index(index),
        .tag(tag), .way(way), .allocate(allocate), .dealloc_mask(dealloc_mask),
        .invalidate(invalidate), .ready(ready), .done(done), .hit(hit),
        .hit_way(hit_way), .inval_vec(inval_vec), .othercpuhit(othercpuhit),
        .multihit(multihit)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [13:0] exp_q[$];
    logic [13:0] obs, e;
    int          lat;
    bit          tmo;

    function automatic logic [13:0] pk(input logic [1:0] h, input logic [3:0] hw,
                                       input logic [5:0] iv, input logic oh, input logic mh);
        return {h, hw, iv, oh, mh};
    endfunction

    // Drives one request from a negedge in IDLE, waits for done, captures results,
    // and returns at the negedge of the cycle after done.
    task automatic run_req(input logic c, input logic [6:0] i, input logic [28:0] t,
                           input logic [1:0] w, input logic a, input logic [1:0] dm,
                           input logic inv, input logic [13:0] exp_r);
        exp_q.push_back(exp_r);
        cpu = c; index = i; tag = t; way = w;
        allocate = a; dealloc_mask = dm; invalidate = inv; strobe = 1'b1;
        @(posedge clk);
        @(negedge clk);
        strobe = 1'b0; allocate = 1'b0; invalidate = 1'b0; dealloc_mask = '0;
        lat = 1;
        while (done !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        tmo = (done !== 1'b1);
        obs = {hit, hit_way, inval_vec, othercpuhit, multihit};
        @(negedge clk);
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({hit, hit_way, inval_vec, othercpuhit, multihit, done, ready} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {hit, hit_way, inval_vec, othercpuhit, multihit, done, ready});
        end
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 128; k++) begin
            if (ready !== 1'b0) bad++;
            @(negedge clk);
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL init_ready_low: ready high in %0d of 128 init cycles, want 0", bad);
        end
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++;
            $display("FAIL init_ready_rise: ready=%b at cycle 128, want 1", ready);
        end
        run_req(1'b0, 7'd77, 29'h0ABCDEF, 2'd0, 1'b0, 2'b00, 1'b0, 14'h0);
        e = exp_q.pop_front(); n_cmp++;
        if (tmo || obs !== e) begin n_bad++; $display("FAIL post_init_query77: got %h want %h tmo=%0d", obs, e, tmo); end
        run_req(1'b1, 7'd127, 29'h0, 2'd0, 1'b0, 2'b00, 1'b0, 14'h0);
        e = exp_q.pop_front(); n_cmp++;
        if (tmo || obs !== e) begin n_bad++; $display("FAIL post_init_query127: got %h want %h tmo=%0d", obs, e, tmo); end
    endtask

    task automatic test_alloc_query();
        run_req(1'b0, 7'd5, 29'h1234, 2'd2, 1'b1, 2'b00, 1'b0, 14'h0);
        e = exp_q.pop_front(); n_cmp++;
        if (tmo || obs !== e) begin n_bad++; $display("FAIL alloc_cpu0: got %h want %h tmo=%0d", obs, e, tmo); end
        n_cmp++;
        if (lat != 2) begin n_bad++; $display("FAIL alloc_latency: done after %0d cycles, want 2", lat); end
        run_req(1'b1, 7'd5, 29'h1234, 2'd0, 1'b0, 2'b00, 1'b0, pk(2'b01, 4'b0010, 6'b000010, 1'b1, 1'b0));
        e = exp_q.pop_front(); n_cmp++;
        if (tmo || obs !== e) begin n_bad++; $display("FAIL query_cpu1: got %h want %h tmo=%0d", obs, e, tmo); end
        n_cmp++;
        if (lat != 2) begin n_bad++; $display("FAIL query_latency: done after %0d cycles, want 2", lat); end
        run_req(1'b0, 7'd5, 29'h1234, 2'd0, 1'b0, 2'b00, 1'b0, pk(2'b01, 4'b0010, 6'b000010, 1'b0, 1'b0));
        e = exp_q.pop_front(); n_cmp++;
        if (tmo || obs !== e) begin n_bad++; $display("FAIL query_cpu0_self: got %h want %h tmo=%0d", obs, e, tmo); end
        run_req(1'b1, 7'd5, 29'h1235, 2'd0, 1'b0, 2'b00, 1'b0, 14'h0);
        e = exp_q.pop_front(); n_cmp++;
        if (tmo || obs !== e) begin n_bad++; $display("FAIL query_other_tag: got %h want %h tmo=%0d", obs, e, tmo); end
        // Second copy of the same tag in way 3 forces a multihit; lowest way stays 2.
        run_req(1'b0, 7'd5, 29'h1234, 2'd3, 1'b1, 2'b00, 1'b0, pk(2'b01, 4'b0010, 6'b000010, 1'b0, 1'b0));
        e = exp_q.pop_front(); n_cmp++;
        if (tmo || obs !== e) begin n_bad++; $display("FAIL alloc_dup_way3: got %h want %h tmo=%0d", obs, e, tmo); end
        run_req(1'b1, 7'd5, 29'h1234, 2'd0, 1'b0, 2'b00, 1'b0, pk(2'b01, 4'b0010, 6'b000010, 1'b1, 1'b1));
        e = exp_q.pop_front(); n_cmp++;
        if (tmo || obs !== e) begin n_bad++; $display("FAIL multihit_query: got %h want %h tmo=%0d", obs, e, tmo); end
        run_req(1'b0, 7'd5, 29'h0, 2'd3, 1'b0, 2'b00, 1'b1, 14'h0);
        e = exp_q.pop_front(); n_cmp++;
        if (tmo || obs !== e) begin n_bad++; $display("FAIL inval_way3: got %h want %h tmo=%0d", obs, e, tmo); end
        run_req(1'b1, 7'd5, 29'h1234, 2'd0, 1'b0, 2'b00, 1'b0, pk(2'b01, 4'b0010, 6'b000010, 1'b1, 1'b0));
        e = exp_q.pop_front(); n_cmp++;
        if (tmo || obs !== e) begin n_bad++; $display("FAIL single_after_inval: got %h want %h tmo=%0d", obs, e, tmo); end
    endtask

    task automatic test_dealloc();
        run_req(1'b1, 7'd5, 29'h1234, 2'd0, 1'b0, 2'b01, 1'b0, pk(2'b01, 4'b0010, 6'b000110, 1'b1, 1'b0));
        e = exp_q.pop_front(); n_cmp++;
        if (tmo || obs !== e) begin n_bad++; $display("FAIL dealloc_vec: got %h want %h tmo=%0d", obs, e, tmo); end
        run_req(1'b1, 7'd5, 29'h1234, 2'd0, 1'b0, 2'b00, 1'b0, 14'h0);
        e = exp_q.pop_front(); n_cmp++;
        if (tmo || obs !== e) begin n_bad++; $display("FAIL dealloc_gone: got %h want %h tmo=%0d", obs, e, tmo); end
    endtask

    task automatic test_invalidate();
        run_req(1'b0, 7'd5, 29'h1234, 2'd2, 1'b1, 2'b00, 1'b0, 14'h0);
        e = exp_q.pop_front(); n_cmp++;
        if (tmo || obs !== e) begin n_bad++; $display("FAIL realloc: got %h want %h tmo=%0d", obs, e, tmo); end
        run_req(1'b0, 7'd5, 29'h0999, 2'd2, 1'b0, 2'b00, 1'b1, 14'h0);
        e = exp_q.pop_front(); n_cmp++;
        if (tmo || obs !== e) begin n_bad++; $display("FAIL inval_mismatch_tag: got %h want %h tmo=%0d", obs, e, tmo); end
        run_req(1'b0, 7'd5, 29'h1234, 2'd0, 1'b0, 2'b00, 1'b0, 14'h0);
        e = exp_q.pop_front(); n_cmp++;
        if (tmo || obs !== e) begin n_bad++; $display("FAIL inval_gone: got %h want %h tmo=%0d", obs, e, tmo); end
        run_req(1'b1, 7'd9, 29'h55, 2'd1, 1'b1, 2'b00, 1'b1, 14'h0);
        e = exp_q.pop_front(); n_cmp++;
        if (tmo || obs !== e) begin n_bad++; $display("FAIL alloc_and_inval: got %h want %h tmo=%0d", obs, e, tmo); end
        run_req(1'b1, 7'd9, 29'h55, 2'd0, 1'b0, 2'b00, 1'b0, 14'h0);
        e = exp_q.pop_front(); n_cmp++;
        if (tmo || obs !== e) begin n_bad++; $display("FAIL inval_beats_alloc: got %h want %h tmo=%0d", obs, e, tmo); end
    endtask

    task automatic test_ignored_strobe();
        int nd;
        run_req(1'b1, 7'd20, 29'hABC, 2'd1, 1'b1, 2'b00, 1'b0, 14'h0);
        e = exp_q.pop_front(); n_cmp++;
        if (tmo || obs !== e) begin n_bad++; $display("FAIL alloc_cpu1_20: got %h want %h tmo=%0d", obs, e, tmo); end
        exp_q.push_back(pk(2'b10, 4'b0100, 6'b001000, 1'b1, 1'b0));
        cpu = 1'b0; index = 7'd20; tag = 29'hABC; way = 2'd0; strobe = 1'b1;
        obs = '0;
        @(posedge clk);
        @(negedge clk);
        nd = 0;
        if (done === 1'b1) nd++;
        allocate = 1'b1; way = 2'd0; strobe = 1'b1;
        @(negedge clk);
        if (done === 1'b1) begin
            nd++;
            obs = {hit, hit_way, inval_vec, othercpuhit, multihit};
        end
        @(negedge clk);
        if (done === 1'b1) nd++;
        strobe = 1'b0; allocate = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        n_cmp++;
        if (nd != 1) begin n_bad++; $display("FAIL ignored_done_count: %0d done pulses, want 1", nd); end
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL ignored_result: got %h want %h", obs, e); end
        run_req(1'b0, 7'd20, 29'hABC, 2'd0, 1'b0, 2'b00, 1'b0, pk(2'b10, 4'b0100, 6'b001000, 1'b1, 1'b0));
        e = exp_q.pop_front(); n_cmp++;
        if (tmo || obs !== e) begin n_bad++; $display("FAIL ignored_no_alloc: got %h want %h tmo=%0d", obs, e, tmo); end
    endtask

    task automatic test_back_to_back();
        run_req(1'b1, 7'd40, 29'h3C, 2'd3, 1'b1, 2'b00, 1'b0, 14'h0);
        e = exp_q.pop_front(); n_cmp++;
        if (tmo || obs !== e) begin n_bad++; $display("FAIL b2b_alloc: got %h want %h tmo=%0d", obs, e, tmo); end
        n_cmp++;
        if (ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: ready=%b three cycles after strobe, want 1", ready); end
        run_req(1'b0, 7'd40, 29'h3C, 2'd0, 1'b0, 2'b00, 1'b0, pk(2'b10, 4'b1100, 6'b011000, 1'b1, 1'b0));
        e = exp_q.pop_front(); n_cmp++;
        if (tmo || obs !== e) begin n_bad++; $display("FAIL b2b_query: got %h want %h tmo=%0d", obs, e, tmo); end
    endtask

    task automatic test_reset_during_cmp();
        int bad;
        run_req(1'b1, 7'd30, 29'h777, 2'd1, 1'b1, 2'b00, 1'b0, 14'h0);
        e = exp_q.pop_front(); n_cmp++;
        if (tmo || obs !== e) begin n_bad++; $display("FAIL rst_pre_alloc: got %h want %h tmo=%0d", obs, e, tmo); end
        cpu = 1'b0; index = 7'd30; tag = 29'h777; way = 2'd1; allocate = 1'b1; strobe = 1'b1;
        @(posedge clk);
        @(negedge clk);
        strobe = 1'b0; allocate = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || hit !== 2'b10) begin
            n_bad++;
            $display("FAIL rst_cmp_seen: done=%b hit=%b, want done=1 hit=10", done, hit);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({hit, hit_way, inval_vec, othercpuhit, multihit, done, ready} !== 16'h0) begin
            n_bad++;
            $display("FAIL rst_cmp_outputs: got %h want 0",
                     {hit, hit_way, inval_vec, othercpuhit, multihit, done, ready});
        end
        bad = 0;
        for (int k = 0; k < 128; k++) begin
            if (ready !== 1'b0) bad++;
            @(negedge clk);
        end
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL rst_cmp_init_low: ready high in %0d of 128 cycles, want 0", bad); end
        n_cmp++;
        if (ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmp_init_rise: ready=%b at cycle 128, want 1", ready); end
        run_req(1'b1, 7'd30, 29'h777, 2'd0, 1'b0, 2'b00, 1'b0, 14'h0);
        e = exp_q.pop_front(); n_cmp++;
        if (tmo || obs !== e) begin n_bad++; $display("FAIL rst_cmp_no_commit: got %h want %h tmo=%0d", obs, e, tmo); end
    endtask

    initial begin
        test_reset();
        test_alloc_query();
        test_dealloc();
        test_invalidate();
        test_ignored_strobe();
        test_back_to_back();
        test_reset_during_cmp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/l1dir_mc.md
# l1dir_mc

Parametrised multi-CPU L1 coherence directory: the generalised successor of the fixed two-CPU directory. It holds a shadow copy of the valid bits and tags of every CPU's L1 cache, for `NCPU` CPUs and `WAYS` ways. Each bridge request is a three-state sequence: look up all copies, report hits and the per-CPU invalidation vector, then commit allocate/deallocate/invalidate updates. It sits between the bridge request decoder and the return-packet builder.

## Interface
- `NCPU`, default 2: number of CPUs (shadowed caches), 1..8.
- `WAYS`, default 4: associativity, a power of 2; `WAY_W = log2(WAYS)`.
- `IDX_W`, default 7: set index width; `SETS = 2**IDX_W`.
- `TAG_W`, default 29: tag width.
- `clk`  in  1  sole clock; all state on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `strobe`  in  1  request valid; accepted only when `ready`=1.
- `cpu`  in  max(1,log2 NCPU)  requesting CPU.
- `index`  in  IDX_W  set index.
- `tag`  in  TAG_W  line tag.
- `way`  in  WAY_W  way for allocate/invalidate.
- `allocate`  in  1  install `tag` in the requester copy at `[index][way]`.
- `dealloc_mask`  in  NCPU  CPUs whose matching entry is cleared.
- `invalidate`  in  1  clear the requester copy at `[index][way]`, no tag compare.
- `ready`  out  1  idle and initialised; can accept `strobe`.
- `done`  out  1  one-cycle pulse; result outputs are valid in this cycle.
- `hit`  out  NCPU  per-CPU tag hit at `index`.
- `hit_way`  out  NCPU*WAY_W  per-CPU hit way; CPU c occupies `[c*WAY_W +: WAY_W]`.
- `inval_vec`  out  NCPU*(WAY_W+1)  per-CPU `{inval, way}`; `inval = hit[c] & dealloc_mask[c]`.
- `othercpuhit`  out  1  OR of `hit` over CPUs other than the requester.
- `multihit`  out  1  more than one way matched in any single CPU copy (error flag).

## Operation
- Storage: one valid bit and one `TAG_W` tag per CPU × set × way. Tag storage is synchronous-read RAM. Valid bits are flops.
- States:
  - INIT: a counter walks 0..SETS-1 and clears the valid bits of all CPUs and ways at that set, then goes to IDLE.
  - IDLE: `ready`=1.
  - READ: RAM read.
  - CMP: compare, drive outputs, commit writes.
  - CMP always returns to IDLE.
- Request fields are latched on an accepted `strobe`. A `strobe` seen while `ready`=0 is ignored; there is no queueing.
- CMP for each CPU c:
  - Compute the per-way match `valid & tag==latched tag`.
  - `hit[c]` is the OR of the matches.
  - `hit_way[c]` is the lowest matching way, or 0 if there is no match.
  - `multihit` is set if any CPU has two or more matching ways.
- Commit at the end of CPU c's CMP cycle, in priority order:
  1. `invalidate` and c is the requester: clear `[index][way]`.
  2. `allocate` and c is the requester: set valid and write the tag at `[index][way]`. This wins over `dealloc_mask[cpu]`.
  3. `dealloc_mask[c]` and `hit[c]`: clear the valid bits of every matching way.
- `allocate` and `invalidate` together: `invalidate` wins and there is no tag write.
- A request with no op bits set is a pure query: outputs only, no state change.
- Result outputs hold their value until the next `done`. They are not cleared on return to IDLE.

## Timing
- Reset: at any state, the next edge enters INIT with counter 0. Every output goes to 0, including `ready`. A pending commit is discarded.
- INIT lasts exactly SETS cycles; `ready` rises in cycle SETS after reset deasserts.
- Strobe accepted at edge T:
  - READ during T+1.
  - CMP during T+2, with `done`=1 in that cycle.
  - Writes are visible from T+3.
  - `ready` is 0 during T+1..T+2 and 1 again at T+3.
- Maximum throughput: one request per 3 cycles.
- Back-to-back requests to the same set always see the previous commit, because the commit completes before the next READ.
- Index wrap: the INIT counter stops at SETS-1; there is no rollover into IDLE traffic.

## Test plan
- Reset, default params: `ready`=0 for 128 cycles, then 1. A query to any set returns `hit`=00 and `multihit`=0.
- CPU0 allocates index 5, tag 0x1234, way 2; then CPU1 queries the same line:
  - `hit`=01, `hit_way[1:0]`=2, `othercpuhit`=1.
  - `done` asserts 2 cycles after each strobe.
- After the allocate above, CPU1 request with `dealloc_mask`=01:
  - `inval_vec[2:0]`={1,2'b10}.
  - A following query returns `hit`=00.
- CPU0 `invalidate` at way 2 with a mismatching tag: the entry is cleared, and a following query of tag 0x1234 misses.
- Strobe pulses at T+1 and T+2 after an accepted strobe: exactly one `done`, no state change from the ignored strobes.
- Assert `reset` during CMP of an allocate: the allocation is not committed, INIT repeats 128 cycles, and a subsequent query misses.
